// File: rtl/alu_controller.sv
// rtl/alu_controller.sv - multi-cycle RV32I ALU-class control unit driving an external combinational alu
//
// Optional feature macro: ALU_CONTROLLER_BRANCH_EN
//   When defined, BEQ/BNE (opcode 0x63) are supported.
//   When undefined, 0x63 is illegal and branch_taken/branch_offset are tied 0.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   instr_valid/instr_ready   instruction handshake; instr sampled on acceptance
//   rs1_addr, rs2_addr        register file read addresses (driven during DECODE)
//   rs1_data, rs2_data        asynchronous register file read data
//   alu_control, alu_a, alu_b registered alu controls/operands (valid during EXECUTE)
//   alu_result, alu_overflow, alu_zero, alu_equal   alu outputs
//   rd_we, rd_addr, rd_data   write-back (one-cycle pulse in WRITEBACK)
//   done, illegal, overflow_flag                    end-of-instruction status
//   branch_taken, branch_offset                     branch decision
//
// alu_control encoding:
//   0 reserved (alu result 0), 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR,
//   6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU

module alu_controller #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [31:0]  instr,
    output logic [4:0]   rs1_addr,
    output logic [4:0]   rs2_addr,
    input  logic [N-1:0] rs1_data,
    input  logic [N-1:0] rs2_data,
    output logic [3:0]   alu_control,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    input  logic [N-1:0] alu_result,
    input  logic         alu_overflow,
    input  logic         alu_zero,
    input  logic         alu_equal,
    output logic         rd_we,
    output logic [4:0]   rd_addr,
    output logic [N-1:0] rd_data,
    output logic         done,
    output logic         illegal,
    output logic         overflow_flag,
    output logic         branch_taken,
    output logic [N-1:0] branch_offset
);

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;

    localparam logic [6:0] OPC_REG    = 7'h33;
    localparam logic [6:0] OPC_IMM    = 7'h13;
`ifdef ALU_CONTROLLER_BRANCH_EN
    localparam logic [6:0] OPC_BRANCH = 7'h63;
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] instr_q;

    // Fields of the latched instruction
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];

    // Register file is only addressed while decoding; 0 otherwise
    assign rs1_addr = (state == DECODE) ? instr_q[19:15] : 5'd0;
    assign rs2_addr = (state == DECODE) ? instr_q[24:20] : 5'd0;

    logic [N-1:0] imm_i;
    logic [N-1:0] shamt;
    assign imm_i = {{(N-12){instr_q[31]}}, instr_q[31:20]};
    assign shamt = {{(N-5){1'b0}}, instr_q[24:20]};

    // Registered between DECODE and WRITEBACK
    logic       ill_q;
    logic       wr_q;
    logic [4:0] rd_q;

    // alu_zero is not needed: equality comes from alu_equal
    logic unused_inputs;
    assign unused_inputs = alu_zero ^ alu_equal;

    // ---------------------------------------------------------------
    // Decode of the latched instruction (used during DECODE)
    // ---------------------------------------------------------------
    logic [3:0]   dec_op;
    logic         dec_legal;
    logic [N-1:0] dec_b;
    logic         dec_writes_rd;
`ifdef ALU_CONTROLLER_BRANCH_EN
    logic         dec_branch;
`endif

    always_comb begin
        dec_op        = ALU_NONE;
        dec_legal     = 1'b0;
        dec_b         = '0;
        dec_writes_rd = 1'b0;
`ifdef ALU_CONTROLLER_BRANCH_EN
        dec_branch    = 1'b0;
`endif
        case (opcode)
            OPC_REG: begin
                dec_b         = rs2_data;
                dec_writes_rd = 1'b1;
                if (funct7 == 7'h00) begin
                    dec_legal = 1'b1;
                    case (funct3)
                        3'b000:  dec_op = ALU_ADD;
                        3'b001:  dec_op = ALU_SLL;
                        3'b010:  dec_op = ALU_SLT;
                        3'b011:  dec_op = ALU_SLTU;
                        3'b100:  dec_op = ALU_XOR;
                        3'b101:  dec_op = ALU_SRL;
                        3'b110:  dec_op = ALU_OR;
                        default: dec_op = ALU_AND;
                    endcase
                end else if (funct7 == 7'h20) begin
                    // Only SUB and SRA use the alternate funct7
                    if (funct3 == 3'b000) begin
                        dec_legal = 1'b1;
                        dec_op    = ALU_SUB;
                    end else if (funct3 == 3'b101) begin
                        dec_legal = 1'b1;
                        dec_op    = ALU_SRA;
                    end
                end
            end
            OPC_IMM: begin
                dec_b         = imm_i;
                dec_writes_rd = 1'b1;
                case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_op = ALU_ADD;  end
                    3'b010: begin dec_legal = 1'b1; dec_op = ALU_SLT;  end
                    3'b011: begin dec_legal = 1'b1; dec_op = ALU_SLTU; end
                    3'b100: begin dec_legal = 1'b1; dec_op = ALU_XOR;  end
                    3'b110: begin dec_legal = 1'b1; dec_op = ALU_OR;   end
                    3'b111: begin dec_legal = 1'b1; dec_op = ALU_AND;  end
                    3'b001: begin
                        // Shift-immediates take a zero-extended 5-bit amount;
                        // the upper immediate bits act as funct7
                        dec_b = shamt;
                        if (funct7 == 7'h00) begin
                            dec_legal = 1'b1;
                            dec_op    = ALU_SLL;
                        end
                    end
                    default: begin
                        dec_b = shamt;
                        if (funct7 == 7'h00) begin
                            dec_legal = 1'b1;
                            dec_op    = ALU_SRL;
                        end else if (funct7 == 7'h20) begin
                            dec_legal = 1'b1;
                            dec_op    = ALU_SRA;
                        end
                    end
                endcase
            end
`ifdef ALU_CONTROLLER_BRANCH_EN
            OPC_BRANCH: begin
                // BEQ/BNE compare via subtraction and the alu equality flag
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    dec_legal  = 1'b1;
                    dec_op     = ALU_SUB;
                    dec_b      = rs2_data;
                    dec_branch = 1'b1;
                end
            end
`endif
            default: ;
        endcase

        // An illegal instruction still walks the pipeline but drives nothing
        if (!dec_legal) begin
            dec_op        = ALU_NONE;
            dec_b         = '0;
            dec_writes_rd = 1'b0;
`ifdef ALU_CONTROLLER_BRANCH_EN
            dec_branch    = 1'b0;
`endif
        end
    end

`ifdef ALU_CONTROLLER_BRANCH_EN
    logic         br_q;
    logic         bne_q;
    logic [N-1:0] boff_q;
    logic [N-1:0] imm_b;
    assign imm_b = {{(N-13){instr_q[31]}}, instr_q[31], instr_q[7],
                    instr_q[30:25], instr_q[11:8], 1'b0};
`else
    assign branch_taken  = 1'b0;
    assign branch_offset = '0;
`endif

    // ---------------------------------------------------------------
    // Control FSM with registered outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            instr_q       <= '0;
            instr_ready   <= 1'b1;
            alu_control   <= ALU_NONE;
            alu_a         <= '0;
            alu_b         <= '0;
            rd_we         <= 1'b0;
            rd_addr       <= '0;
            rd_data       <= '0;
            done          <= 1'b0;
            illegal       <= 1'b0;
            overflow_flag <= 1'b0;
            ill_q         <= 1'b0;
            wr_q          <= 1'b0;
            rd_q          <= '0;
`ifdef ALU_CONTROLLER_BRANCH_EN
            branch_taken  <= 1'b0;
            branch_offset <= '0;
            br_q          <= 1'b0;
            bne_q         <= 1'b0;
            boff_q        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        instr_q     <= instr;
                        instr_ready <= 1'b0;
                        state       <= DECODE;
                    end
                end
                DECODE: begin
                    alu_control <= dec_op;
                    alu_a       <= dec_legal ? rs1_data : '0;
                    alu_b       <= dec_b;
                    ill_q       <= !dec_legal;
                    wr_q        <= dec_writes_rd;
                    rd_q        <= instr_q[11:7];
`ifdef ALU_CONTROLLER_BRANCH_EN
                    br_q        <= dec_branch;
                    bne_q       <= funct3[0];
                    boff_q      <= dec_branch ? imm_b : '0;
`endif
                    state       <= EXECUTE;
                end
                EXECUTE: begin
                    done          <= 1'b1;
                    illegal       <= ill_q;
                    rd_we         <= wr_q && (rd_q != 5'd0);
                    rd_addr       <= wr_q ? rd_q : 5'd0;
                    rd_data       <= wr_q ? alu_result : '0;
                    overflow_flag <= ill_q ? 1'b0 : alu_overflow;
`ifdef ALU_CONTROLLER_BRANCH_EN
                    branch_taken  <= br_q && (alu_equal ^ bne_q);
                    branch_offset <= boff_q;
`endif
                    alu_control   <= ALU_NONE;
                    alu_a         <= '0;
                    alu_b         <= '0;
                    state         <= WRITEBACK;
                end
                default: begin
                    done          <= 1'b0;
                    illegal       <= 1'b0;
                    rd_we         <= 1'b0;
                    rd_addr       <= '0;
                    rd_data       <= '0;
                    overflow_flag <= 1'b0;
`ifdef ALU_CONTROLLER_BRANCH_EN
                    branch_taken  <= 1'b0;
                    branch_offset <= '0;
`endif
                    instr_ready   <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule
